// File: rtl/cmp_defs.sv
// Shared definitions for the compare arbiter: FSM state encoding and the
// ALUFun[3:1] compare codes understood by the shared comparator.
package cmp_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] FUN_NEQ = 3'b000;
    localparam logic [2:0] FUN_EQ  = 3'b001;
    localparam logic [2:0] FUN_LT  = 3'b010;
    localparam logic [2:0] FUN_LTZ = 3'b101;
    localparam logic [2:0] FUN_LEZ = 3'b110;
    localparam logic [2:0] FUN_GTZ = 3'b111;

    // Codes 011 and 100 have no compare meaning; the arbiter flags them as errors.
    function automatic logic fun_supported(input logic [2:0] fun);
        logic ok;
        case (fun)
            FUN_EQ, FUN_NEQ, FUN_LT, FUN_LEZ, FUN_LTZ, FUN_GTZ: ok = 1'b1;
            default:                                           ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational winner select; the last-grant pointer lives in the
// parent so this block stays purely combinational.
module rr_arb2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    // Only a tie needs a decision: the requester not served last time wins,
    // unless fixed priority pins the win to requester 0.
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = (FIXED_PRIO || last) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/cmp_arb.sv
// Arbitrates the branch unit and the set-less-than unit onto one shared
// ADD/SUB comparator, one operation at a time (IDLE -> EXEC -> RESP).
module cmp_arb
    import cmp_defs::*;
#(
    parameter int DW         = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [DW-1:0] req_a0,
    input  logic [DW-1:0] req_b0,
    input  logic [DW-1:0] req_a1,
    input  logic [DW-1:0] req_b1,
    input  logic [2:0]    req_fun0,
    input  logic [2:0]    req_fun1,
    output logic [1:0]    resp_valid,
    input  logic [1:0]    resp_ready,
    output logic          resp_s,
    output logic          resp_err,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic          alu_sub,
    output logic [2:0]    alu_fun3to1,
    input  logic          alu_s0,
    output logic          busy
);

    state_t        state;
    state_t        state_nx;
    logic          last_grant;
    logic          winner;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic [2:0]    fun_q;
    logic          s_q;
    logic          err_q;
    logic [1:0]    grant;

    rr_arb2 #(
        .FIXED_PRIO(FIXED_PRIO != 0)
    ) u_arb (
        .valid(req_valid),
        .last (last_grant),
        .grant(grant)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // req_ready is gated by reset so nothing is accepted while reset is held.
    always_comb begin
        state_nx   = state;
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        alu_sub    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (reset && (grant != 2'b00)) begin
                    req_ready = grant;
                    state_nx  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_sub  = 1'b1;
                state_nx = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = winner ? 2'b10 : 2'b01;
                if (resp_ready[winner]) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b1;
            winner     <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            fun_q      <= 3'b000;
            s_q        <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (req_ready != 2'b00) begin
                winner     <= req_ready[1];
                last_grant <= req_ready[1];
                a_q        <= req_ready[1] ? req_a1 : req_a0;
                b_q        <= req_ready[1] ? req_b1 : req_b0;
                fun_q      <= req_ready[1] ? req_fun1 : req_fun0;
            end
            // Unsupported codes still spend their EXEC cycle but report S=0.
            if (state == ST_EXEC) begin
                s_q   <= fun_supported(fun_q) ? alu_s0 : 1'b0;
                err_q <= !fun_supported(fun_q);
            end
        end
    end

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_fun3to1 = fun_q;
    assign resp_s      = s_q;
    assign resp_err    = err_q;
    assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_cmp_arb.sv
// Self-checking bench for cmp_arb: a round-robin instance and a fixed-priority
// instance, each fed by a behavioural comparator on its datapath ports.
module tb_cmp_arb;

    localparam int DW = 32;
    localparam logic signed [DW-1:0] ZERO = '0;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req_valid, resp_ready, req_valid_fp, resp_ready_fp;
    logic [DW-1:0] req_a0, req_b0, req_a1, req_b1;
    logic [2:0]    req_fun0, req_fun1;

    logic [1:0]    req_ready, resp_valid, req_ready_fp, resp_valid_fp;
    logic          resp_s, resp_err, alu_sub, alu_s0, busy;
    logic          resp_s_fp, resp_err_fp, alu_sub_fp, alu_s0_fp, busy_fp;
    logic [DW-1:0] alu_a, alu_b, alu_a_fp, alu_b_fp;
    logic [2:0]    alu_fun3to1, alu_fun_fp;

    int checks = 0;
    int errors = 0;
    int model_last = 1;

    always #5 clk = ~clk;

    // Comparator reference: signed compares; meaningless codes answer 1 so a
    // missing force-to-zero in the DUT is visible.
    function automatic logic ref_cmp(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                     input logic [2:0] fun);
        logic signed [DW-1:0] sa, sb;
        sa = a;
        sb = b;
        case (fun)
            3'b001:  return a == b;
            3'b000:  return a != b;
            3'b010:  return sa < sb;
            3'b110:  return sa <= ZERO;
            3'b101:  return sa < ZERO;
            3'b111:  return sa > ZERO;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic ref_err(input logic [2:0] fun);
        return (fun == 3'b011) || (fun == 3'b100);
    endfunction

    function automatic int exp_winner(input logic [1:0] v);
        if (v == 2'b11) return (model_last == 1) ? 0 : 1;
        return v[1] ? 1 : 0;
    endfunction

    function automatic logic [DW-1:0] rand_operand();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(DW-1){1'b0}}};
            3:       return DW'($urandom_range(0, 3));
            default: return DW'($urandom);
        endcase
    endfunction

    assign alu_s0    = ref_cmp(alu_a, alu_b, alu_fun3to1);
    assign alu_s0_fp = ref_cmp(alu_a_fp, alu_b_fp, alu_fun_fp);

    cmp_arb #(.DW(DW), .FIXED_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_fun0(req_fun0), .req_fun1(req_fun1),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_s(resp_s), .resp_err(resp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sub(alu_sub),
        .alu_fun3to1(alu_fun3to1), .alu_s0(alu_s0), .busy(busy)
    );

    cmp_arb #(.DW(DW), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_fp), .req_ready(req_ready_fp),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_fun0(req_fun0), .req_fun1(req_fun1),
        .resp_valid(resp_valid_fp), .resp_ready(resp_ready_fp),
        .resp_s(resp_s_fp), .resp_err(resp_err_fp),
        .alu_a(alu_a_fp), .alu_b(alu_b_fp), .alu_sub(alu_sub_fp),
        .alu_fun3to1(alu_fun_fp), .alu_s0(alu_s0_fp), .busy(busy_fp)
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        req_valid = 2'b00; req_valid_fp = 2'b00;
        resp_ready = 2'b00; resp_ready_fp = 2'b00;
        @(negedge clk);
        reset = 1'b1;
        model_last = 1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_valid = 2'b11; req_valid_fp = 2'b11;
        @(negedge clk); #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_req_ready: got %b expected 00", req_ready);
        end
        checks++;
        if ({resp_valid, resp_s, resp_err, busy, alu_sub} !== 6'b0) begin
            errors++; $display("[TB] FAIL reset_ctrl: got %b expected 000000",
                               {resp_valid, resp_s, resp_err, busy, alu_sub});
        end
        checks++;
        if ({alu_a, alu_b, alu_fun3to1} !== '0) begin
            errors++; $display("[TB] FAIL reset_datapath: got %h/%h/%b expected 0/0/000",
                               alu_a, alu_b, alu_fun3to1);
        end
        checks++;
        if ({req_ready_fp, resp_valid_fp, resp_s_fp, resp_err_fp, alu_sub_fp, busy_fp} !== 8'b0) begin
            errors++; $display("[TB] FAIL reset_fp_ctrl: got %b expected 00000000",
                               {req_ready_fp, resp_valid_fp, resp_s_fp, resp_err_fp, alu_sub_fp, busy_fp});
        end
        @(negedge clk);
        reset = 1'b1;
        req_valid = 2'b00; req_valid_fp = 2'b00;
        model_last = 1;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_no_accept: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_single_lt();
        @(negedge clk);
        req_valid = 2'b01; req_a0 = 32'hFFFF_FFFF; req_b0 = 32'h1; req_fun0 = 3'b010;
        resp_ready = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("[TB] FAIL lt_accept: got %b expected 01", req_ready);
        end
        model_last = 0;
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        checks++;
        if ({resp_valid, alu_sub, alu_a, alu_b, alu_fun3to1} !== {2'b00, 1'b1, 32'hFFFF_FFFF, 32'h1, 3'b010}) begin
            errors++; $display("[TB] FAIL lt_exec: got rv=%b sub=%b a=%h b=%h f=%b expected rv=00 sub=1 a=ffffffff b=00000001 f=010",
                               resp_valid, alu_sub, alu_a, alu_b, alu_fun3to1);
        end
        @(negedge clk); #1;
        checks++;
        if ({resp_valid, resp_s, resp_err} !== 4'b0110) begin
            errors++; $display("[TB] FAIL lt_resp: got rv=%b s=%b err=%b expected rv=01 s=1 err=0",
                               resp_valid, resp_s, resp_err);
        end
        @(negedge clk); #1;
        checks++;
        if ({busy, resp_valid, alu_sub, alu_a} !== {4'b0000, 32'hFFFF_FFFF}) begin
            errors++; $display("[TB] FAIL lt_idle_hold: got busy=%b rv=%b sub=%b a=%h expected 0/00/0/ffffffff",
                               busy, resp_valid, alu_sub, alu_a);
        end
        resp_ready = 2'b00;
    endtask

    task automatic test_random();
        logic [1:0]    pat, exp_rv;
        logic [DW-1:0] ea, eb;
        logic [2:0]    ef;
        logic          es, ee;
        int            w, stall;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            pat = 2'($urandom_range(1, 3));
            req_a0 = rand_operand(); req_b0 = ($urandom_range(0, 3) == 0) ? req_a0 : rand_operand();
            req_a1 = rand_operand(); req_b1 = ($urandom_range(0, 3) == 0) ? req_a1 : rand_operand();
            req_fun0 = 3'($urandom_range(0, 7)); req_fun1 = 3'($urandom_range(0, 7));
            req_valid = pat; resp_ready = 2'b00;
            w = exp_winner(pat);
            exp_rv = (w == 1) ? 2'b10 : 2'b01;
            ea = (w == 1) ? req_a1 : req_a0;
            eb = (w == 1) ? req_b1 : req_b0;
            ef = (w == 1) ? req_fun1 : req_fun0;
            ee = ref_err(ef);
            es = ee ? 1'b0 : ref_cmp(ea, eb, ef);
            #1;
            checks++;
            if (req_ready !== exp_rv) begin
                errors++; $display("[TB] FAIL rand_grant[%0d]: got %b expected %b (valid %b)", n, req_ready, exp_rv, pat);
            end
            model_last = w;
            @(negedge clk);
            req_valid = 2'b00;
            #1;
            checks++;
            if ({alu_sub, req_ready, alu_a, alu_b, alu_fun3to1} !== {1'b1, 2'b00, ea, eb, ef}) begin
                errors++; $display("[TB] FAIL rand_exec[%0d]: got sub=%b rdy=%b a=%h b=%h f=%b expected 1/00/%h/%h/%b",
                                   n, alu_sub, req_ready, alu_a, alu_b, alu_fun3to1, ea, eb, ef);
            end
            @(negedge clk);
            resp_ready = ~exp_rv;
            #1;
            checks++;
            if ({resp_valid, resp_s, resp_err} !== {exp_rv, es, ee}) begin
                errors++; $display("[TB] FAIL rand_resp[%0d]: got rv=%b s=%b err=%b expected rv=%b s=%b err=%b",
                                   n, resp_valid, resp_s, resp_err, exp_rv, es, ee);
            end
            stall = $urandom_range(0, 3);
            for (int k = 0; k < stall; k++) begin
                @(negedge clk); #1;
                checks++;
                if ({resp_valid, resp_s} !== {exp_rv, es}) begin
                    errors++; $display("[TB] FAIL rand_stall[%0d]: got rv=%b s=%b expected rv=%b s=%b",
                                       n, resp_valid, resp_s, exp_rv, es);
                end
            end
            @(negedge clk);
            resp_ready = exp_rv;
            #1;
            checks++;
            if (resp_valid !== exp_rv) begin
                errors++; $display("[TB] FAIL rand_other_ready_ignored[%0d]: got rv=%b expected %b", n, resp_valid, exp_rv);
            end
            @(negedge clk);
            resp_ready = 2'b00;
            #1;
            checks++;
            if ({busy, resp_valid} !== 3'b000) begin
                errors++; $display("[TB] FAIL rand_done[%0d]: got busy=%b rv=%b expected 0/00", n, busy, resp_valid);
            end
        end
    endtask

    task automatic test_unsupported();
        int exec_cycles, resp_cycles;
        exec_cycles = 0;
        resp_cycles = 0;
        @(negedge clk);
        req_valid = 2'b10; req_a1 = 32'h5; req_b1 = 32'h5; req_fun1 = 3'b100;
        resp_ready = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++; $display("[TB] FAIL unsup_accept: got %b expected 10", req_ready);
        end
        model_last = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req_valid = 2'b00;
            #1;
            if (alu_sub === 1'b1) exec_cycles++;
            if (resp_valid === 2'b10) begin
                resp_cycles++;
                checks++;
                if ({resp_s, resp_err} !== 2'b01) begin
                    errors++; $display("[TB] FAIL unsup_result: got s=%b err=%b expected s=0 err=1", resp_s, resp_err);
                end
            end
        end
        checks++;
        if (exec_cycles != 1 || resp_cycles != 1) begin
            errors++; $display("[TB] FAIL unsup_cycles: got exec=%0d resp=%0d expected exec=1 resp=1", exec_cycles, resp_cycles);
        end
        resp_ready = 2'b00;
    endtask

    task automatic test_resp_stall();
        @(negedge clk);
        req_valid = 2'b01; req_a0 = 32'h1234; req_b0 = 32'h1234; req_fun0 = 3'b001;
        resp_ready = 2'b00;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("[TB] FAIL stall_accept: got %b expected 01", req_ready);
        end
        model_last = 0;
        @(negedge clk);
        req_valid = 2'b11;
        resp_ready = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++; $display("[TB] FAIL stall_exec_ready: got %b expected 00", req_ready);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            checks++;
            if ({resp_valid, resp_s, req_ready} !== 5'b01100) begin
                errors++; $display("[TB] FAIL stall_hold[%0d]: got rv=%b s=%b rdy=%b expected rv=01 s=1 rdy=00",
                                   k, resp_valid, resp_s, req_ready);
            end
        end
        @(negedge clk);
        resp_ready = 2'b01;
        #1;
        checks++;
        if ({resp_valid, req_ready} !== 4'b0100) begin
            errors++; $display("[TB] FAIL stall_handshake: got rv=%b rdy=%b expected rv=01 rdy=00", resp_valid, req_ready);
        end
        @(negedge clk);
        resp_ready = 2'b00;
        #1;
        checks++;
        if ({busy, req_ready} !== {1'b0, (exp_winner(2'b11) == 1) ? 2'b10 : 2'b01}) begin
            errors++; $display("[TB] FAIL stall_idle_grant: got busy=%b rdy=%b expected busy=0 rdy=10", busy, req_ready);
        end
        req_valid = 2'b00;
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("[TB] FAIL stall_withdraw: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int accepts[$];
        int grants[$];
        int ew;
        do_reset();
        @(negedge clk);
        req_valid = 2'b11; resp_ready = 2'b11;
        req_a0 = rand_operand(); req_b0 = rand_operand(); req_fun0 = 3'b010;
        req_a1 = rand_operand(); req_b1 = rand_operand(); req_fun1 = 3'b001;
        for (int c = 0; c < 14 && accepts.size() < 4; c++) begin
            #1;
            checks++;
            if (req_ready === 2'b11) begin
                errors++; $display("[TB] FAIL b2b_onehot: got %b expected at most one bit", req_ready);
            end
            if (req_ready !== 2'b00) begin
                accepts.push_back(c);
                grants.push_back(int'(req_ready[1]));
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        checks++;
        if (accepts.size() != 4) begin
            errors++; $display("[TB] FAIL b2b_count: got %0d accepts expected 4 within 14 cycles", accepts.size());
        end
        for (int i = 0; i < accepts.size(); i++) begin
            ew = exp_winner(2'b11);
            model_last = ew;
            checks++;
            if (grants[i] != ew) begin
                errors++; $display("[TB] FAIL b2b_grant[%0d]: got %0d expected %0d", i, grants[i], ew);
            end
            if (i > 0) begin
                checks++;
                if (accepts[i] - accepts[i-1] != 3) begin
                    errors++; $display("[TB] FAIL b2b_spacing[%0d]: got %0d cycles expected 3", i, accepts[i] - accepts[i-1]);
                end
            end
        end
        repeat (3) @(negedge clk);
        resp_ready = 2'b00;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_drain: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_fixed_prio();
        int grants0;
        grants0 = 0;
        do_reset();
        @(negedge clk);
        req_valid_fp = 2'b11; resp_ready_fp = 2'b11;
        for (int c = 0; c < 15; c++) begin
            #1;
            if (req_ready_fp !== 2'b00) begin
                checks++;
                if (req_ready_fp !== 2'b01) begin
                    errors++; $display("[TB] FAIL fp_grant[%0d]: got %b expected 01", c, req_ready_fp);
                end else begin
                    grants0++;
                end
            end
            @(negedge clk);
        end
        req_valid_fp = 2'b00;
        checks++;
        if (grants0 != 5) begin
            errors++; $display("[TB] FAIL fp_count: got %0d grants to 0 expected 5", grants0);
        end
        repeat (3) @(negedge clk);
        resp_ready_fp = 2'b00;
        #1;
        checks++;
        if (busy_fp !== 1'b0) begin
            errors++; $display("[TB] FAIL fp_drain: busy got %b expected 0", busy_fp);
        end
    endtask

    task automatic test_reset_in_exec();
        @(negedge clk);
        req_valid = 2'b01; req_a0 = rand_operand(); req_b0 = rand_operand(); req_fun0 = 3'b010;
        resp_ready = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("[TB] FAIL rexec_accept: got %b expected 01", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        checks++;
        if (alu_sub !== 1'b1) begin
            errors++; $display("[TB] FAIL rexec_in_exec: alu_sub got %b expected 1", alu_sub);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_s, resp_err, busy, alu_sub, alu_fun3to1, alu_a, alu_b} !== '0) begin
            errors++; $display("[TB] FAIL rexec_clear: got rdy=%b rv=%b s=%b err=%b busy=%b sub=%b f=%b a=%h b=%h expected all 0",
                               req_ready, resp_valid, resp_s, resp_err, busy, alu_sub, alu_fun3to1, alu_a, alu_b);
        end
        @(negedge clk);
        reset = 1'b1;
        model_last = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            checks++;
            if ({resp_valid, busy} !== 3'b000) begin
                errors++; $display("[TB] FAIL rexec_no_resp[%0d]: got rv=%b busy=%b expected 00/0", c, resp_valid, busy);
            end
        end
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("[TB] FAIL rexec_tie: got %b expected 01", req_ready);
        end
        req_valid = 2'b00;
        resp_ready = 2'b00;
        @(negedge clk);
    endtask

    initial begin
        req_valid = 2'b00; req_valid_fp = 2'b00;
        resp_ready = 2'b00; resp_ready_fp = 2'b00;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        req_fun0 = 3'b000; req_fun1 = 3'b000;
        reset = 1'b0;
        test_reset();
        test_single_lt();
        test_random();
        test_unsupported();
        test_resp_stall();
        test_back_to_back();
        test_fixed_prio();
        test_reset_in_exec();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
